// File: rtl/dice_pkg.sv
// Shared types and widths for the dice roll controller and its pip decoder.
package dice_pkg;

  localparam int FACE_W = 3;
  localparam int PIP_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Next face with wrap from the highest face back to 1.
  function automatic logic [FACE_W-1:0] next_face(input logic [FACE_W-1:0] cur,
                                                  input logic [FACE_W-1:0] top);
    next_face = (cur == top) ? FACE_W'(1) : cur + FACE_W'(1);
  endfunction

endpackage

// File: rtl/eight_dice.sv
// Combinational 3x3 pip decoder: face value to row-major pattern, MSB top-left.
module eight_dice
  import dice_pkg::*;
(
  input  logic [FACE_W-1:0] s,
  output logic [PIP_W-1:0]  out
);

  always_comb begin
    out = '0;
    case (s)
      3'd1:    out = 9'b000_010_000;
      3'd2:    out = 9'b100_000_001;
      3'd3:    out = 9'b100_010_001;
      3'd4:    out = 9'b101_000_101;
      3'd5:    out = 9'b101_010_101;
      3'd6:    out = 9'b111_000_111;
      3'd7:    out = 9'b111_010_111;
      default: out = 9'b000_000_000;
    endcase
  end

endmodule

// File: rtl/dice_roll_controller.sv
// Electronic die: spins while roll is held, decelerates after release, then holds.
//
// state | meaning
// IDLE  | after reset, face blank (s=0)
// ROLL  | roll held, face advances every DIV cycles
// SLOW  | released, advance k waits DIV*k cycles, k=1..SLOW_STEPS
// HOLD  | result settled, face frozen until next roll edge
module dice_roll_controller
  import dice_pkg::*;
#(
  parameter int FACES      = 6,
  parameter int DIV        = 4,
  parameter int SLOW_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              roll,
  output logic [FACE_W-1:0] s,
  output logic [PIP_W-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam logic [FACE_W-1:0] FACE_TOP = FACE_W'(FACES);
  localparam logic [15:0]       DIV_M1   = 16'(DIV - 1);
  localparam logic [3:0]        K_LAST   = 4'(SLOW_STEPS);

  state_t            state, state_nxt;
  logic [FACE_W-1:0] s_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [3:0]        k, k_nxt;
  logic              done_nxt;
  logic              roll_q;
  logic              rise;

  // The interval timer counts down to zero; loading interval-1 on entry gives
  // the same advance timing as clearing an up-counter and comparing to interval.
  function automatic logic [15:0] slow_reload(input logic [3:0] step);
    slow_reload = 16'(DIV) * {12'd0, step} - 16'd1;
  endfunction

  assign rise = roll & ~roll_q;
  assign busy = (state == ROLL) || (state == SLOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s      <= '0;
      cnt    <= '0;
      k      <= '0;
      done   <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      s      <= s_nxt;
      cnt    <= cnt_nxt;
      k      <= k_nxt;
      done   <= done_nxt;
      roll_q <= roll;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    k_nxt     = k;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (rise) begin
          state_nxt = ROLL;
          s_nxt     = FACE_W'(1);
          cnt_nxt   = DIV_M1;
        end
      end
      ROLL: begin
        if (!roll) begin
          state_nxt = SLOW;
          k_nxt     = 4'd1;
          cnt_nxt   = slow_reload(4'd1);
        end else if (cnt == 16'd0) begin
          s_nxt   = next_face(s, FACE_TOP);
          cnt_nxt = DIV_M1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      SLOW: begin
        // roll is deliberately not looked at here
        if (cnt == 16'd0) begin
          s_nxt = next_face(s, FACE_TOP);
          if (k == K_LAST) begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
            k_nxt     = 4'd0;
          end else begin
            k_nxt   = k + 4'd1;
            cnt_nxt = slow_reload(k + 4'd1);
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  eight_dice u_pips (
    .s  (s),
    .out(out)
  );

endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench: FACES=6/DIV=4/SLOW_STEPS=2 instance plus a FACES=7 instance.
module tb_dice_roll_controller;

  logic       clk;
  logic       rst_n;
  logic       roll, roll2;
  logic [2:0] s, s2;
  logic [8:0] out, out2;
  logic       busy, busy2, done, done2;

  int checks = 0;
  int errors = 0;

  dice_roll_controller #(.FACES(6), .DIV(4), .SLOW_STEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .roll(roll),
    .s(s), .out(out), .busy(busy), .done(done)
  );

  dice_roll_controller #(.FACES(7), .DIV(4), .SLOW_STEPS(2)) dut7 (
    .clk(clk), .rst_n(rst_n), .roll(roll2),
    .s(s2), .out(out2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] es, input logic [8:0] eo,
                         input logic eb, input logic ed);
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".out"}, 32'(out), 32'(eo));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0;
    roll  = 1'b0;
    roll2 = 1'b0;
    tick(3);
    chk_all("reset", 3'd0, 9'b000000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    chk_all("idle", 3'd0, 9'b000000000, 1'b0, 1'b0);

    // roll held: entry, first advance, wrap
    roll = 1'b1;
    tick();
    chk_all("entry", 3'd1, 9'b000010000, 1'b1, 1'b0);
    tick(3);
    chk("pre_adv.s", 32'(s), 32'd1);
    tick();
    chk_all("adv2", 3'd2, 9'b100000001, 1'b1, 1'b0);
    tick(16);
    chk_all("face6", 3'd6, 9'b111000111, 1'b1, 1'b0);
    tick(4);
    chk_all("wrap1", 3'd1, 9'b000010000, 1'b1, 1'b0);
    tick(8);
    chk_all("face3", 3'd3, 9'b100010001, 1'b1, 1'b0);

    // release while s=3
    roll = 1'b0;
    tick();
    chk_all("slow_entry", 3'd3, 9'b100010001, 1'b1, 1'b0);
    tick(3);
    chk("slow_pre1.s", 32'(s), 32'd3);
    tick();
    chk_all("slow_adv1", 3'd4, 9'b101000101, 1'b1, 1'b0);
    tick(7);
    chk_all("slow_pre2", 3'd4, 9'b101000101, 1'b1, 1'b0);
    tick();
    chk_all("settle", 3'd5, 9'b101010101, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_all("hold", 3'd5, 9'b101010101, 1'b0, 1'b0);
    end

    // restart from HOLD, then release with a roll pulse during SLOW
    roll = 1'b1;
    tick();
    chk_all("restart", 3'd1, 9'b000010000, 1'b1, 1'b0);
    tick(8);
    chk("r_face3.s", 32'(s), 32'd3);
    roll = 1'b0;
    tick();
    chk("r_slow.busy", 32'(busy), 32'd1);
    tick();
    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    chk_all("ign_pre1", 3'd3, 9'b100010001, 1'b1, 1'b0);
    tick();
    chk_all("ign_adv1", 3'd4, 9'b101000101, 1'b1, 1'b0);
    tick(7);
    chk_all("ign_pre2", 3'd4, 9'b101000101, 1'b1, 1'b0);
    tick();
    chk_all("ign_settle", 3'd5, 9'b101010101, 1'b0, 1'b1);
    tick();
    chk("ign_done_off", 32'(done), 32'd0);

    // asynchronous reset mid-ROLL, roll held across release
    roll = 1'b1;
    tick();
    chk("pre_rst.s", 32'(s), 32'd1);
    tick(4);
    chk("pre_rst2.s", 32'(s), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 9'b000000000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk_all("rst_release_edge", 3'd1, 9'b000010000, 1'b1, 1'b0);
    roll = 1'b0;
    tick(20);
    chk_all("post_rst_settle", 3'd3, 9'b100010001, 1'b0, 1'b0);

    // FACES=7 instance
    roll2 = 1'b1;
    tick();
    chk("f7_entry.s", 32'(s2), 32'd1);
    for (int i = 1; i <= 28; i++) begin
      tick();
      chk("f7_nonzero", 32'(s2 != 3'd0), 32'd1);
      if (i == 24) begin
        chk("f7_face7.s", 32'(s2), 32'd7);
        chk("f7_face7.out", 32'(out2), 32'(9'b111010111));
      end
      if (i == 28) chk("f7_wrap.s", 32'(s2), 32'd1);
    end
    chk("f7_busy", 32'(busy2), 32'd1);
    chk("f7_done", 32'(done2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
